// File: rtl/simmem_rsp_delay_buf.sv
// Response delay buffer: holds memory responses until their per-request latency expires.
// Optional SIMMEM_RSP_DELAY_STATS_EN adds a released-response counter output.

module simmem_rsp_delay_slot #(
  parameter int DataW = 64,
  parameter int LatW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rsv_en,
  input  logic             fill_en,
  input  logic             rel_en,
  input  logic [LatW-1:0]  lat,
  input  logic [DataW-1:0] data_in,
  output logic             is_wait,
  output logic             rdy,
  output logic [DataW-1:0] data_q
);
  typedef enum logic [1:0] {FREE, WAIT, HELD} slot_st_e;

  slot_st_e        st_q, st_d;
  logic [LatW-1:0] cnt_q;
  logic            ripe_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= FREE;
      cnt_q  <= '0;
      ripe_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (rsv_en)
        cnt_q <= lat;
      else if (st_q != FREE && cnt_q != '0)
        cnt_q <= cnt_q - LatW'(1);
      // data must sit one full cycle in HELD before it may be released
      ripe_q <= (st_q == HELD) && !rel_en;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en) data_q <= data_in;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      FREE:    if (rsv_en)  st_d = WAIT;
      WAIT:    if (fill_en) st_d = HELD;
      HELD:    if (rel_en)  st_d = FREE;
      default: st_d = FREE;
    endcase
  end

  assign is_wait = (st_q == WAIT);
  assign rdy     = (st_q == HELD) && ripe_q && (cnt_q == '0);
endmodule

module simmem_rsp_delay_buf #(
  parameter int DataW = 64,
  parameter int Depth = 8,
  parameter int LatW  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [LatW-1:0]        req_lat_i,
  input  logic                   rsp_in_valid_i,
  output logic                   rsp_in_ready_o,
  input  logic [DataW-1:0]       rsp_in_data_i,
  output logic                   rsp_out_valid_o,
  input  logic                   rsp_out_ready_i,
  output logic [DataW-1:0]       rsp_out_data_o,
  output logic [$clog2(Depth):0] occupancy_o
`ifdef SIMMEM_RSP_DELAY_STATS_EN
  ,
  output logic [31:0]            released_cnt_o
`endif
);
  localparam int PW = $clog2(Depth);
  localparam logic [PW:0] FullCnt = (PW+1)'(Depth);

  logic [PW-1:0]                rsv_ptr, fill_ptr, rel_ptr;
  logic [Depth-1:0]             rsv_en, fill_en, rel_en, slot_wait, slot_rdy;
  logic [Depth-1:0][DataW-1:0]  slot_data;
  logic                         rsv_hs, fill_hs, rel_hs;

  assign req_ready_o     = occupancy_o < FullCnt;
  // fill always points at the oldest reservation still waiting for data
  assign rsp_in_ready_o  = slot_wait[fill_ptr];
  assign rsp_out_valid_o = slot_rdy[rel_ptr];
  assign rsp_out_data_o  = rsp_out_valid_o ? slot_data[rel_ptr] : '0;

  assign rsv_hs  = req_valid_i && req_ready_o;
  assign fill_hs = rsp_in_valid_i && rsp_in_ready_o;
  assign rel_hs  = rsp_out_valid_o && rsp_out_ready_i;

  for (genvar i = 0; i < Depth; i++) begin : g_slot
    assign rsv_en[i]  = rsv_hs  && (rsv_ptr  == PW'(i));
    assign fill_en[i] = fill_hs && (fill_ptr == PW'(i));
    assign rel_en[i]  = rel_hs  && (rel_ptr  == PW'(i));

    simmem_rsp_delay_slot #(.DataW(DataW), .LatW(LatW)) u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .rsv_en  (rsv_en[i]),
      .fill_en (fill_en[i]),
      .rel_en  (rel_en[i]),
      .lat     (req_lat_i),
      .data_in (rsp_in_data_i),
      .is_wait (slot_wait[i]),
      .rdy     (slot_rdy[i]),
      .data_q  (slot_data[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsv_ptr     <= '0;
      fill_ptr    <= '0;
      rel_ptr     <= '0;
      occupancy_o <= '0;
    end else begin
      if (rsv_hs)  rsv_ptr  <= rsv_ptr  + PW'(1);
      if (fill_hs) fill_ptr <= fill_ptr + PW'(1);
      if (rel_hs)  rel_ptr  <= rel_ptr  + PW'(1);
      case ({rsv_hs, rel_hs})
        2'b10:   occupancy_o <= occupancy_o + (PW+1)'(1);
        2'b01:   occupancy_o <= occupancy_o - (PW+1)'(1);
        default: occupancy_o <= occupancy_o;
      endcase
    end
  end

`ifdef SIMMEM_RSP_DELAY_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)       released_cnt_o <= '0;
    else if (rel_hs) released_cnt_o <= released_cnt_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_simmem_rsp_delay_buf.sv
// Randomized + directed bench for simmem_rsp_delay_buf against a queue-based timing model.
module tb_simmem_rsp_delay_buf;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, rsp_in_valid = 1'b0, rsp_out_ready = 1'b0;
  logic [7:0]  req_lat = '0;
  logic [63:0] rsp_in_data = '0;
  logic        req_ready, rsp_in_ready, rsp_out_valid;
  logic [63:0] rsp_out_data;
  logic [3:0]  occupancy;
`ifdef SIMMEM_RSP_DELAY_STATS_EN
  logic [31:0] released_cnt;
`endif

  simmem_rsp_delay_buf dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_lat_i       (req_lat),
    .rsp_in_valid_i  (rsp_in_valid),
    .rsp_in_ready_o  (rsp_in_ready),
    .rsp_in_data_i   (rsp_in_data),
    .rsp_out_valid_o (rsp_out_valid),
    .rsp_out_ready_i (rsp_out_ready),
    .rsp_out_data_o  (rsp_out_data),
    .occupancy_o     (occupancy)
`ifdef SIMMEM_RSP_DELAY_STATS_EN
    ,
    .released_cnt_o  (released_cnt)
`endif
  );

  always #5 clk = ~clk;

  // one entry per accepted reservation, oldest first
  typedef struct {
    logic [63:0] data;
    int          t;
    int          lat;
    bit          filled;
    int          fill_k;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] rel_log[$];
  int          rel_k[$];
  int          k, n_rel;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rv, input logic [7:0] lat, input bit iv,
                      input logic [63:0] dat, input bit orr);
    bit          e_rr, e_ir, e_v;
    logic [63:0] e_d;
    int          fi;
    ent_t        ne;
    @(negedge clk);
    e_rr = mq.size() < DEPTH;
    fi = -1;
    foreach (mq[j]) if (!mq[j].filled && fi < 0) fi = j;
    e_ir = (fi >= 0);
    e_v = 1'b0;
    if (mq.size() > 0)
      e_v = mq[0].filled && (k >= mq[0].t + mq[0].lat) && (k >= mq[0].fill_k + 1);
    e_d = e_v ? mq[0].data : 64'd0;
    chk("req_ready", req_ready, e_rr);
    chk("rsp_in_ready", rsp_in_ready, e_ir);
    chk("rsp_out_valid", rsp_out_valid, e_v);
    chk("rsp_out_data", rsp_out_data, e_d);
    chk("occupancy", occupancy, mq.size());
`ifdef SIMMEM_RSP_DELAY_STATS_EN
    chk("released_cnt", released_cnt, n_rel);
`endif
    req_valid = rv; req_lat = lat; rsp_in_valid = iv; rsp_in_data = dat; rsp_out_ready = orr;
    @(posedge clk);
    k++;
    if (e_v && orr) begin
      rel_log.push_back(mq[0].data);
      rel_k.push_back(k);
      void'(mq.pop_front());
      n_rel++;
      fi--;
    end
    if (e_ir && iv) begin
      mq[fi].filled = 1'b1;
      mq[fi].data   = dat;
      mq[fi].fill_k = k;
    end
    if (e_rr && rv) begin
      ne.data = '0; ne.t = k; ne.lat = lat; ne.filled = 1'b0; ne.fill_k = 0;
      mq.push_back(ne);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 0; rsp_in_valid = 0; rsp_out_ready = 0;
    @(posedge clk);
    mq.delete(); n_rel = 0; k = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_in_ready", rsp_in_ready, 0);
    chk("rst_rsp_out_valid", rsp_out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_rsp_out_data", rsp_out_data, 0);
`ifdef SIMMEM_RSP_DELAY_STATS_EN
    chk("rst_released_cnt", released_cnt, 0);
`endif
    @(posedge clk);
    k++;
  endtask

  task automatic drain();
    repeat (40) step(0, 0, 1, {$urandom, $urandom}, 1);
    #1 chk("drain_empty", occupancy, 0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] da, db;
    int ta;
    do_reset();

    // lat=5 reserved at edge t, data at t+1 -> valid first at t+5
    da = rnd64();
    step(1, 5, 0, 0, 0);
    step(0, 0, 1, da, 0);
    repeat (3) begin
      step(0, 0, 0, 0, 0);
      #1 chk("tc035_not_yet", rsp_out_valid, 0);
    end
    step(0, 0, 0, 0, 0);
    #1 chk("tc035_valid", rsp_out_valid, 1);
    chk("tc035_data", rsp_out_data, da);
    step(0, 0, 0, 0, 1);

    // lat=2, data 10 edges later -> valid one edge after the data
    da = rnd64();
    step(1, 2, 0, 0, 0);
    repeat (9) step(0, 0, 0, 0, 0);
    step(0, 0, 1, da, 0);
    #1 chk("tc036_fill_cycle", rsp_out_valid, 0);
    step(0, 0, 0, 0, 0);
    #1 chk("tc036_valid", rsp_out_valid, 1);
    step(0, 0, 0, 0, 1);

    // fill all slots, then one release reopens a slot
    repeat (DEPTH) step(1, 0, 0, 0, 0);
    #1 chk("tc037_full_ready", req_ready, 0);
    chk("tc037_full_occ", occupancy, DEPTH);
    step(0, 0, 1, rnd64(), 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    #1 chk("tc037_reopen_ready", req_ready, 1);
    chk("tc037_reopen_occ", occupancy, DEPTH - 1);
    drain();

    // long-latency head blocks an expired younger entry
    rel_log.delete(); rel_k.delete();
    da = rnd64(); db = rnd64();
    step(1, 20, 0, 0, 0);
    ta = k;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, da, 1);
    step(0, 0, 1, db, 1);
    repeat (30) step(0, 0, 0, 0, 1);
    chk("tc038_first", rel_log[0], da);
    chk("tc038_second", rel_log[1], db);
    chk("tc038_a_latency", rel_k[0] > ta + 20, 1);
    chk("tc038_b_after_a", rel_k[1] > rel_k[0], 1);

    // response with no waiting slot is refused; concurrent ops keep occupancy
    step(0, 0, 1, rnd64(), 0);
    #1 chk("tc039_no_wait_occ", occupancy, 0);
    chk("tc039_no_wait_ready", rsp_in_ready, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, rnd64(), 0);
    step(0, 0, 0, 0, 0);
    step(1, 3, 1, rnd64(), 1);
    #1 chk("tc039_same_cycle_occ", occupancy, 2);
    drain();

    // reset with three held entries discards them
    repeat (3) step(1, 50, 0, 0, 0);
    repeat (3) step(0, 0, 1, rnd64(), 0);
    #1 chk("tc040_held_occ", occupancy, 3);
    do_reset();

    // randomized traffic in phases of differing pressure
    for (int ph = 0; ph < 6; ph++) begin
      int prv, piv, por;
      prv = $urandom_range(20, 90);
      piv = $urandom_range(20, 90);
      por = $urandom_range(10, 95);
      repeat (500) begin
        logic [7:0] l;
        l = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
        step($urandom_range(0, 99) < prv, l, $urandom_range(0, 99) < piv, rnd64(),
             $urandom_range(0, 99) < por);
      end
      if (ph == 3) do_reset();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/simmem_rsp_delay_buf.md
SIMMEM_RSP_DELAY_BUF -- requirements
Module: simmem_rsp_delay_buf

Interface
REQ-001 SHALL have parameter DataW, default 64, response payload width in bits.
REQ-002 SHALL have parameter Depth, default 8, number of slots; power of two, minimum 2.
REQ-003 SHALL have parameter LatW, default 8, width of the per-request latency field.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid_i  input  1  address request (reservation) valid.
REQ-007 SHALL have port req_ready_o  output  1  reservation accepted.
REQ-008 SHALL have port req_lat_i  input  LatW  delay in cycles for this request.
REQ-009 SHALL have port rsp_in_valid_i  input  1  response from the real memory controller valid.
REQ-010 SHALL have port rsp_in_ready_o  output  1  buffer can store a response.
REQ-011 SHALL have port rsp_in_data_i  input  DataW  response payload.
REQ-012 SHALL have port rsp_out_valid_o  output  1  delayed response available to the requester.
REQ-013 SHALL have port rsp_out_ready_i  input  1  requester accepts the response.
REQ-014 SHALL have port rsp_out_data_o  output  DataW  released payload.
REQ-015 SHALL have port occupancy_o  output  $clog2(Depth)+1  number of reserved slots.

Function
REQ-016 SHALL implement a circular slot array with three pointers: rsv (next reservation), fill (oldest reserved slot without data), rel (head to release).
REQ-017 SHALL give each slot the state FREE, WAIT (reserved, no data) or HELD (data stored), plus a LatW-bit countdown.
REQ-018 SHALL assert req_ready_o iff occupancy_o < Depth; there is no same-cycle bypass of a release.
REQ-019 SHALL, on req handshake, set slot[rsv] to WAIT, load its countdown with req_lat_i, and advance rsv modulo Depth.
REQ-020 SHALL decrement every non-FREE slot countdown by 1 each cycle after loading, saturating at 0.
REQ-021 SHALL assert rsp_in_ready_o iff at least one WAIT slot exists, i.e. fill != rsv or the slot at fill is WAIT while full.
REQ-022 SHALL, on rsp_in handshake, write rsp_in_data_i into slot[fill], set it to HELD, and advance fill; responses pair with reservations in order.
REQ-023 SHALL assert rsp_out_valid_o iff slot[rel] is HELD and its countdown is 0; rsp_out_data_o SHALL come from slot[rel] and stay stable while valid and not ready.
REQ-024 SHALL, on rsp_out handshake, set slot[rel] to FREE and advance rel.
REQ-025 SHALL meet minimum latency: a request accepted on edge t with req_lat_i = L SHALL have its response valid no earlier than cycle t+L, and no earlier than the cycle after its data is accepted.
REQ-026 SHALL release a response whose data arrives after the countdown expires in the cycle after the data is accepted.
REQ-027 SHALL handle reservation, data fill and release in the same cycle, each on a distinct slot, with occupancy_o = old + rsv_hs - rel_hs.
REQ-028 SHALL wrap all pointers modulo Depth; full and empty SHALL be distinguished by occupancy_o, not by pointer equality.
REQ-029 SHALL keep releases in reservation order; a later slot with expired countdown SHALL wait behind an unexpired head.

Reset
REQ-030 SHALL, while rst_i is high at an edge, set all slots FREE, all pointers to 0, and all countdowns to 0.
REQ-031 SHALL hold reset output values req_ready_o=1, rsp_in_ready_o=0, rsp_out_valid_o=0, occupancy_o=0, rsp_out_data_o=0.
REQ-032 SHALL, on reset mid-operation, discard all reserved and held entries with no output handshake.

Configuration
REQ-033 SHALL, when SIMMEM_RSP_DELAY_STATS_EN is defined, add output released_cnt_o (32 bits), reset to 0 and incremented per rsp_out handshake, wrapping at 2^32.
REQ-034 SHALL, when SIMMEM_RSP_DELAY_STATS_EN is undefined, have neither the released_cnt_o port nor its counter; all other behaviour SHALL be identical.

Verification
REQ-035 SHALL cover: reserve with lat=5 at edge 0, data at edge 1 -> rsp_out_valid_o first high in cycle 5 with the data.
REQ-036 SHALL cover: reserve with lat=2, data at edge 10 -> valid in cycle 11.
REQ-037 SHALL cover: Depth=8, 8 reservations without release -> req_ready_o=0, occupancy_o=8; one release -> req_ready_o=1 the next cycle.
REQ-038 SHALL cover: reserve A with lat=20, then B with lat=0, both filled -> B not released before A; A then B in order.
REQ-039 SHALL cover: rsp_in_valid_i=1 with no WAIT slot -> rsp_in_ready_o=0, no state change; a same-cycle reserve, fill and release keeps occupancy_o unchanged.
REQ-040 SHALL cover: rst_i pulsed with 3 held entries -> next cycle occupancy_o=0, rsp_out_valid_o=0, and released_cnt_o=0 if SIMMEM_RSP_DELAY_STATS_EN is defined.
